// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC result serializer.
// Contents: mode tag constants, serializer FSM state type and the
// per-mode frame length helper.
`timescale 1ns/1ps
package cdc_pkg;

    localparam logic [1:0] MODE_CRC_GEN = 2'd0;
    localparam logic [1:0] MODE_CRC_CHK = 2'd1;
    localparam logic [1:0] MODE_HAMMING = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Frame length in bytes for the default 72-bit result word.
    function automatic logic [7:0] frame_len(input logic [1:0] mode);
        return (mode == MODE_CRC_GEN) ? 8'd9 : 8'd1;
    endfunction

endpackage

// File: rtl/cdc_out_fifo.sv
// Synchronous FIFO holding {mode, data} result entries.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write strobe and entry
//   pop, rdata     read strobe and head entry (valid while !empty)
//   full, empty    occupancy flags
//   count          number of stored entries (0..DEPTH)
`timescale 1ns/1ps
module cdc_out_fifo #(
    parameter int W     = 74,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdc_out_serializer.sv
// Receive-domain result serializer: captures result words, queues them and
// streams each one out as a valid/ready byte frame, MSB byte first.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_data/in_mode  one-cycle result pulse with word and mode tag
//   out_valid/out_ready       byte stream handshake
//   out_byte/out_last/out_mode current byte, end-of-frame marker, frame mode
//   overflow                  sticky: a result was dropped on a full FIFO
//   crc_fail_cnt              saturating count of non-zero mode-1 results
//
// state   | meaning
// ST_IDLE | no frame in flight; loads the next FIFO head if present
// ST_SEND | presenting bytes of the current frame
`timescale 1ns/1ps
module cdc_out_serializer
    import cdc_pkg::*;
#(
    parameter int DATA_W = 72,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [1:0]        out_mode,
    output logic              overflow,
    output logic [CNT_W-1:0]  crc_fail_cnt
);

    localparam int FW = DATA_W + 2;

    state_t              state;
    logic                cap_valid;
    logic [DATA_W-1:0]   cap_data;
    logic [1:0]          cap_mode;
    logic [DATA_W-1:0]   shreg;
    logic [7:0]          byte_cnt;

    logic [FW-1:0]       head;
    logic [DATA_W-1:0]   head_data;
    logic [1:0]          head_mode;
    logic [7:0]          head_len;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                accept;
    logic                push;
    logic                pop;

    // Input capture stage; it sets the two-cycle in_valid to out_valid latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_mode  <= '0;
        end else begin
            cap_valid <= in_valid;
            if (in_valid) begin
                cap_data <= in_data;
                cap_mode <= in_mode;
            end
        end
    end

    assign pop    = (state == ST_IDLE) && !fifo_empty;
    assign accept = cap_valid && (cap_mode != MODE_RSVD);
    assign push   = accept && (!fifo_full || pop);

    cdc_out_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({cap_mode, cap_data}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_mode = head[FW-1 -: 2];
    assign head_data = head[DATA_W-1:0];
    assign head_len  = (head_mode == MODE_CRC_GEN) ? 8'(DATA_W/8) : frame_len(head_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow     <= 1'b0;
            crc_fail_cnt <= '0;
        end else begin
            if (accept && !push) overflow <= 1'b1;
            if (push && cap_mode == MODE_CRC_CHK && cap_data != '0 && crc_fail_cnt != '1) begin
                crc_fail_cnt <= crc_fail_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_mode  <= '0;
            shreg     <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    if (pop) begin
                        // Single-byte frames are placed in the top byte so the
                        // output path is the same for every mode.
                        case (head_mode)
                            MODE_CRC_CHK: shreg <= {head_data[7:0], {(DATA_W-8){1'b0}}};
                            MODE_HAMMING: shreg <= {1'b0, head_data[6:0], {(DATA_W-8){1'b0}}};
                            default:      shreg <= head_data;
                        endcase
                        byte_cnt  <= head_len - 8'd1;
                        out_last  <= (head_len == 8'd1);
                        out_mode  <= head_mode;
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (byte_cnt == 8'd0) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            shreg    <= {shreg[DATA_W-9:0], 8'h00};
                            byte_cnt <= byte_cnt - 8'd1;
                            out_last <= (byte_cnt == 8'd1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_byte = shreg[DATA_W-1 -: 8];

endmodule

// File: tb/tb_cdc_out_serializer.sv
`timescale 1ns/1ps
module tb_cdc_out_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [71:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [1:0]  out_mode;
    logic        overflow;
    logic [15:0] crc_fail_cnt;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic [1:0] mode;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    cdc_out_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_byte     (out_byte),
        .out_last     (out_last),
        .out_mode     (out_mode),
        .overflow     (overflow),
        .crc_fail_cnt (crc_fail_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every byte that will handshake at the next rising edge is
    // popped and compared here.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte: got byte=%h last=%b, required no byte", out_byte, out_last);
            end else begin
                e = q.pop_front();
                if (out_byte !== e.b || out_last !== e.last || out_mode !== e.mode) begin
                    failures++;
                    $display("FAIL stream_byte: got byte=%h last=%b mode=%0d, required byte=%h last=%b mode=%0d",
                             out_byte, out_last, out_mode, e.b, e.last, e.mode);
                end
            end
        end
    end

    task automatic push_frame(input logic [71:0] d, input logic [1:0] m);
        exp_t e;
        if (m == 2'd0) begin
            for (int i = 8; i >= 0; i--) begin
                e.b = d[i*8 +: 8];
                e.last = (i == 0);
                e.mode = m;
                q.push_back(e);
            end
        end else begin
            e.b = (m == 2'd1) ? d[7:0] : {1'b0, d[6:0]};
            e.last = 1'b1;
            e.mode = m;
            q.push_back(e);
        end
    endtask

    task automatic pulse(input logic [71:0] d, input logic [1:0] m);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d bytes outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_byte !== 8'h00 || out_mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_stream: got valid=%b last=%b byte=%h mode=%0d, required 0 0 00 0",
                     out_valid, out_last, out_byte, out_mode);
        end
        checks++;
        if (overflow !== 1'b0 || crc_fail_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL reset_status: got overflow=%b crc=%h, required 0 0000", overflow, crc_fail_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_mode0_latency();
        logic [71:0] d;
        d = 72'h0123456789ABCDEF5A;
        out_ready = 1'b1;
        push_frame(d, 2'd0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_t0: got out_valid=%b, required 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_t1: got out_valid=%b, required 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_t2: got out_valid=%b, required 1", out_valid);
        end
        wait_drain("mode0", 50);
    endtask

    task automatic test_mode1();
        out_ready = 1'b1;
        push_frame({72{1'b1}}, 2'd1);
        pulse({72{1'b1}}, 2'd1);
        wait_drain("mode1_fail", 30);
        push_frame(72'h0, 2'd1);
        pulse(72'h0, 2'd1);
        wait_drain("mode1_pass", 30);
        checks++;
        if (crc_fail_cnt !== 16'd1) begin
            failures++;
            $display("FAIL crc_count: got %0d, required 1", crc_fail_cnt);
        end
    endtask

    task automatic test_mode2_mode3();
        int seen = 0;
        out_ready = 1'b1;
        push_frame(72'h123456789ABCDEF0FF, 2'd2);
        pulse(72'h123456789ABCDEF0FF, 2'd2);
        wait_drain("mode2", 30);
        pulse(72'h0123456789ABCDEF5A, 2'd3);
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mode3_silent: got %0d valid cycles, required 0", seen);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL mode3_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        out_ready = 1'b1;
        push_frame(72'h0123456789ABCDEF5A, 2'd0);
        pulse(72'h0123456789ABCDEF5A, 2'd0);
        while (q.size() > 6 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_byte !== 8'h67 || out_last !== 1'b0 || out_mode !== 2'd0) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d got valid=%b byte=%h last=%b mode=%0d, required 1 67 0 0",
                         i, out_valid, out_byte, out_last, out_mode);
            end
        end
        out_ready = 1'b1;
        wait_drain("stall", 50);
    endtask

    // DEPTH=2 plus the word being serialized: three back-to-back results fit,
    // the fourth is dropped.
    task automatic test_overflow_and_reset();
        logic [71:0] d [4];
        d[0] = 72'h111111111111111101;
        d[1] = 72'h222222222222222202;
        d[2] = 72'h333333333333333303;
        d[3] = 72'h444444444444444404;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_frame(d[i], 2'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            in_mode  = 2'd0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got %b, required 1", overflow);
        end
        out_ready = 1'b1;
        wait_drain("overflow", 200);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b0 || crc_fail_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL overflow_clear: got overflow=%b valid=%b crc=%h, required 0 0 0000",
                     overflow, out_valid, crc_fail_cnt);
        end
    endtask

    task automatic test_crc_saturate();
        out_ready = 1'b1;
        @(posedge clk); #1;
        force dut.crc_fail_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.crc_fail_cnt;
        #1;
        checks++;
        if (crc_fail_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL crc_preload: got %h, required ffff", crc_fail_cnt);
        end
        push_frame(72'h1, 2'd1);
        pulse(72'h1, 2'd1);
        wait_drain("crc_sat", 30);
        checks++;
        if (crc_fail_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL crc_saturate: got %h, required ffff", crc_fail_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int seen = 0;
        out_ready = 1'b1;
        push_frame(72'hA1B2C3D4E5F6071829, 2'd0);
        pulse(72'hA1B2C3D4E5F6071829, 2'd0);
        while (q.size() > 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_valid: got %b, required 0", out_valid);
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_residual: got %0d valid cycles, required 0", seen);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        test_reset();
        test_mode0_latency();
        test_mode1();
        test_mode2_mode3();
        test_backpressure();
        test_overflow_and_reset();
        test_crc_saturate();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
